// File: rtl/top.sv
// rtl/top.sv - AXI4-Stream ingress buffer: small FIFO that drops all-null filler beats.
module top #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [KEEP_WIDTH-1:0] S_AXIS_TKEEP,
  input  logic                  S_AXIS_TLAST,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [KEEP_WIDTH-1:0] M_AXIS_TKEEP,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          active;
  logic          is_null;
  logic          store;
  logic          pop;

  // ARESETN is active-high here despite its name.
  // active keeps TREADY low until the first edge after reset release.
  assign S_AXIS_TREADY = active && (count < FULL);
  assign M_AXIS_TVALID = (count != '0);

  assign is_null = (S_AXIS_TKEEP == '0) && !S_AXIS_TLAST;
  assign store   = S_AXIS_TVALID && S_AXIS_TREADY && !is_null;
  assign pop     = M_AXIS_TVALID && M_AXIS_TREADY;

  assign {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} = M_AXIS_TVALID ? mem[rd_ptr] : '0;

  always_ff @(posedge ACLK) begin
    if (store) begin
      mem[wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA};
    end
  end

  always_ff @(posedge ACLK or posedge ARESETN) begin
    if (ARESETN) begin
      active <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      active <= 1'b1;
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - scoreboard bench for the stream ingress buffer.
module tb_top;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b1;
  logic [255:0] s_data = '0;
  logic [31:0]  s_keep = '0;
  logic         s_last = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [255:0] m_data;
  logic [31:0]  m_keep;
  logic         m_last;
  logic         m_valid;
  logic         m_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int stalls = 0;
  int max_cnt = 0;
  bit streaming = 0;
  logic [288:0] q[$];

  always #5 ACLK = ~ACLK;

  top dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TDATA(s_data), .S_AXIS_TKEEP(s_keep), .S_AXIS_TLAST(s_last),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TKEEP(m_keep), .M_AXIS_TLAST(m_last),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready)
  );

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beats are checked at the negedge before the edge that pops them.
  always @(negedge ACLK) begin
    if (streaming && int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
    if (m_valid && m_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", {m_last, m_keep, m_data}, '0);
      end else begin
        chk("beat", {m_last, m_keep, m_data}, q.pop_front());
      end
      pops++;
    end
  end

  task automatic send(input logic [255:0] d, input logic [31:0] k, input logic l);
    int n = 0;
    bit done = 0;
    @(posedge ACLK); #1;
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    while (!done) begin
      @(negedge ACLK);
      if (s_ready) begin
        done = 1;
        if (!(k == '0 && !l)) q.push_back({l, k, d});
      end else if (n > 50) begin
        chk("send_timeout", 0, 1);
        done = 1;
      end else begin
        n++;
        @(posedge ACLK); #1;
      end
    end
    stalls += n;
  endtask

  task automatic idle();
    @(posedge ACLK); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input int exp_pops);
    int n = 0;
    while ((q.size() != 0 || m_valid) && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    chk("drain_timeout", n >= 200, 0);
    chk("pop_count", pops, exp_pops);
    pops = 0;
  endtask

  initial begin
    // Reset held with random stimulus on the slave port.
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK); #1;
      s_data = {8{$urandom()}}; s_keep = $urandom(); s_last = 1'($urandom());
      s_valid = 1'($urandom()); m_ready = 1'($urandom());
      @(negedge ACLK);
      chk("rst_ready", s_ready, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", {m_last, m_keep, m_data}, '0);
    end
    @(posedge ACLK); #1;
    ARESETN = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge ACLK);
    chk("release_ready_early", s_ready, 0);
    @(negedge ACLK);
    chk("release_ready", s_ready, 1);

    // Single beat with one-cycle latency and one-cycle presence.
    send(256'h1234, 32'hFFFFFFFF, 1'b1);
    idle();
    @(negedge ACLK);
    chk("single_valid", m_valid, 1);
    @(negedge ACLK);
    chk("single_gone", m_valid, 0);
    drain(1);

    // Fill and backpressure.
    m_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(256'(i), 32'h1, 1'b0);
        idle();
      end
      begin
        repeat (8) @(negedge ACLK);
        chk("full_ready", s_ready, 0);
        chk("full_head", m_data, 1);
        chk("full_sb", q.size(), 4);
        repeat (3) @(negedge ACLK);
        chk("held_head", {m_last, m_keep, m_data}, {1'b0, 32'h1, 256'h1});
        @(posedge ACLK); #1;
        m_ready = 1'b1;
      end
    join
    drain(6);

    // Null filter.
    send(256'hAA, 32'h0, 1'b0);
    send(256'hBB, 32'h0, 1'b1);
    send(256'hCC, 32'h0000000F, 1'b0);
    idle();
    drain(2);

    // Streaming.
    stalls = 0; max_cnt = 0; streaming = 1;
    for (int i = 0; i < 100; i++)
      send({8{$urandom()}}, 32'hFFFFFFFF, 1'($urandom()));
    idle();
    drain(100);
    streaming = 0;
    chk("stream_stalls", stalls, 0);
    chk("stream_max_count", max_cnt, 1);

    // Mid-stream reset with three beats buffered.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(256'(16'hD00 + i), 32'hF, 1'b0);
    idle();
    @(negedge ACLK);
    chk("pre_reset_valid", m_valid, 1);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    q.delete();
    #1;
    chk("mid_reset_valid", m_valid, 0);
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    m_ready = 1'b1;
    send(256'hE1, 32'hFF, 1'b0);
    send(256'hE2, 32'hFF, 1'b1);
    idle();
    drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/top.md
# top

AXI4-Stream ingress buffer at the head of the tester datapath: accepts 256-bit beats on a slave stream port, stores them in a small synchronous FIFO and presents them on a master stream port with full TVALID/TREADY flow control. All-null filler beats (TKEEP all zero, TLAST low) are consumed and discarded. All other beats pass through unchanged and in order. The block isolates upstream and downstream timing: no combinational path exists from any S_AXIS input to any M_AXIS output, or from M_AXIS_TREADY to S_AXIS_TREADY.

## Interface
- DATA_WIDTH, 256: TDATA width in bits.
- KEEP_WIDTH, 32: TKEEP width; must equal DATA_WIDTH/8.
- DEPTH, 4: FIFO entries; a power of two, at least 2.

- ACLK  in  1  single clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous, active-high reset; asserted when 1.
- S_AXIS_TDATA  in  DATA_WIDTH  input beat data.
- S_AXIS_TKEEP  in  KEEP_WIDTH  input byte qualifiers.
- S_AXIS_TLAST  in  1  input end-of-packet.
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TREADY  out  1  block can accept a beat.
- M_AXIS_TDATA  out  DATA_WIDTH  output beat data.
- M_AXIS_TKEEP  out  KEEP_WIDTH  output byte qualifiers.
- M_AXIS_TLAST  out  1  output end-of-packet.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TREADY  in  1  downstream accepts the output beat.

## Operation
- **Storage:** DEPTH entries, each holding {TLAST, TKEEP, TDATA}.
  - Write pointer, read pointer and occupancy count, each log2(DEPTH)+1 bits wide where needed.
  - Pointers wrap modulo DEPTH.
- **Input handshake:**
  - S_AXIS_TREADY = (count < DEPTH) and not in reset.
  - A beat is accepted when S_AXIS_TVALID and S_AXIS_TREADY are both 1 at a rising edge.
- **Null filter:**
  - An accepted beat with S_AXIS_TKEEP == 0 and S_AXIS_TLAST == 0 is discarded; the FIFO is not written.
  - A beat with TKEEP == 0 and TLAST == 1 is stored, because it carries end-of-packet.
- **Output valid and data:**
  - M_AXIS_TVALID = (count != 0).
  - The M_AXIS_TDATA, M_AXIS_TKEEP and M_AXIS_TLAST outputs show the head entry.
  - Whenever M_AXIS_TVALID = 0, these outputs are forced to all zeros.
- **Output handshake:**
  - A beat is popped when M_AXIS_TVALID and M_AXIS_TREADY are both 1 at a rising edge.
  - While M_AXIS_TVALID = 1 and M_AXIS_TREADY = 0, the head entry is held stable.
- **Count update:** each edge, count += store − pop. Simultaneous store and pop leaves count unchanged.
- **Ordering:** beats leave in acceptance order. TDATA, TKEEP and TLAST are never modified.
- **Reset:** an ARESETN assertion mid-operation clears pointers and count immediately. All buffered beats are lost and no partial packet is completed.

## Timing
- **Reset values (while ARESETN = 1):**
  - S_AXIS_TREADY = 0, M_AXIS_TVALID = 0.
  - M_AXIS_TDATA, M_AXIS_TKEEP and M_AXIS_TLAST = 0.
- S_AXIS_TREADY rises to 1 after the first rising edge of ACLK following ARESETN deassertion.
- **Latency:** a beat stored at edge k appears on M_AXIS (TVALID = 1) after edge k, i.e. one cycle minimum.
- **Throughput:** one beat per cycle sustained when M_AXIS_TREADY is held at 1.
- **Full:** with count == DEPTH, S_AXIS_TREADY = 0 even if a pop occurs in the same cycle; it reasserts the cycle after the pop.
- **Empty:** with count == 0, M_AXIS_TVALID = 0 even if a store occurs in the same cycle.
- S_AXIS_TREADY and M_AXIS_TVALID are decoded from registered count only.

## Test plan
- **Reset values:** hold ARESETN = 1 with random S_AXIS inputs → S_AXIS_TREADY = 0, M_AXIS_TVALID = 0 and all M data outputs = 0 throughout. Release → S_AXIS_TREADY = 1 one edge later.
- **Single beat:** after reset, send one beat (TDATA = 256'h1234, TKEEP = 32'hFFFFFFFF, TLAST = 1) with M_AXIS_TREADY = 1 → the identical beat appears on M_AXIS one cycle later for exactly one cycle.
- **Fill and backpressure:** with M_AXIS_TREADY = 0, send 6 beats with TDATA = 1..6 and TKEEP = 1 →
  - Beats 1–4 are accepted.
  - S_AXIS_TREADY = 0 after the 4th accept.
  - M holds TDATA = 1 steady.
  - Then raise M_AXIS_TREADY → outputs 1,2,3,4,5,6 in order with no loss or duplication.
- **Null filter:** send TKEEP = 0/TLAST = 0, then TKEEP = 0/TLAST = 1, then TKEEP = 32'h0000000F/TLAST = 0 → only the last two beats are output, in that order.
- **Streaming:** with M_AXIS_TREADY = 1 and back-to-back valid beats, 100 beats of random data in → 100 identical beats out, one per cycle; count never exceeds 1.
- **Mid-stream reset:** assert ARESETN for one cycle with 3 beats buffered → M_AXIS_TVALID drops immediately. After release, only newly sent beats are output.
